// File: rtl/stoch_window_counter.sv
// Stochastic-to-binary converter: counts ones over 2^WINDOW_LOG2 valid samples
// and reports the count plus an 8-bit probability estimate on a valid/ready port.
module stoch_window_counter #(
    parameter int WINDOW_LOG2 = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_b_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic                   bit_in_i,
    input  logic                   bit_valid_i,
    input  logic                   result_ready_i,
    output logic                   busy_o,
    output logic [WINDOW_LOG2:0]   result_o,
    output logic [7:0]             prob_est_o,
    output logic                   result_valid_o
);

    localparam int CW = WINDOW_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [WINDOW_LOG2-1:0] sample_cnt_q, sample_cnt_d;
    logic [CW-1:0]          ones_cnt_q, ones_cnt_d;
    logic [CW-1:0]          ones_inc;
    logic [CW-1:0]          result_q, result_d;
    logic [7:0]             prob_q, prob_d;
    logic                   handshake;
    logic                   last_sample;
    logic                   clear;

    // Scale the count down to 8 bits; a full window (2^WINDOW_LOG2) clips to 0xFF.
    function automatic logic [7:0] sat_prob(input logic [CW-1:0] cnt);
        logic [CW-1:0] shifted;
        shifted = cnt >> (WINDOW_LOG2 - 8);
        if (shifted > CW'(255)) begin
            return 8'hFF;
        end
        return shifted[7:0];
    endfunction

    assign handshake   = (state_q == DONE) && result_ready_i;
    assign last_sample = (state_q == COUNT) && bit_valid_i && (sample_cnt_q == '1);
    assign ones_inc    = ones_cnt_q + CW'(bit_in_i);
    assign clear       = abort_i || ((state_q == IDLE) && start_i) || (handshake && start_i);

    always_ff @(posedge clk_i) begin
        if (!rst_b_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = COUNT;
            COUNT:   if (last_sample) state_d = DONE;
            DONE:    if (handshake) state_d = start_i ? COUNT : IDLE;
            default: state_d = IDLE;
        endcase
        // abort outranks both start and the output handshake
        if (abort_i) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        busy_o         = (state_q == COUNT);
        result_valid_o = (state_q == DONE);
        result_o       = result_q;
        prob_est_o     = prob_q;
    end

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        ones_cnt_d   = ones_cnt_q;
        result_d     = result_q;
        prob_d       = prob_q;
        if (clear) begin
            sample_cnt_d = '0;
            ones_cnt_d   = '0;
        end else if ((state_q == COUNT) && bit_valid_i) begin
            sample_cnt_d = sample_cnt_q + WINDOW_LOG2'(1);
            ones_cnt_d   = ones_inc;
            if (last_sample) begin
                result_d = ones_inc;
                prob_d   = sat_prob(ones_inc);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_b_i) begin
            sample_cnt_q <= '0;
            ones_cnt_q   <= '0;
            result_q     <= '0;
            prob_q       <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            ones_cnt_q   <= ones_cnt_d;
            result_q     <= result_d;
            prob_q       <= prob_d;
        end
    end

endmodule

// File: doc/stoch_window_counter.md
# stoch_window_counter

Stochastic-to-binary converter that sits directly downstream of the LFSR comparator (`lfsr_behavioral`). It consumes the comparator's `prob_bit` stream and counts the ones over a fixed window of 2^WINDOW_LOG2 valid samples. It returns the raw ones-count plus an 8-bit probability estimate on a valid/ready output port. The block is the readback path used to check generated bitstreams against the programmed `probability` value.

## Interface
- WINDOW_LOG2, 8, log2 of window length in valid samples; legal range 8..16.
- clk  input  1  clock; all logic is rising-edge.
- rst_b  input  1  reset, synchronous, active-low.
- start  input  1  single-cycle request to begin a window; honoured only in IDLE, or in DONE together with an output handshake.
- abort  input  1  drops the current window; returns to IDLE next cycle.
- bit_in  input  1  stochastic bit (comparator `prob_bit`).
- bit_valid  input  1  qualifies `bit_in`; only cycles with bit_valid=1 count as samples.
- busy  output  1  high in COUNT.
- result  output  WINDOW_LOG2+1  ones-count of the last window, 0..2^WINDOW_LOG2.
- prob_est  output  8  result >> (WINDOW_LOG2-8), saturated to 8'hFF.
- result_valid  output  1  high in DONE.
- result_ready  input  1  consumer accepts result when result_valid && result_ready.

## Operation
- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - start=1: go to COUNT; clear sample_cnt (WINDOW_LOG2 bits) and ones_cnt (WINDOW_LOG2+1 bits).
  - otherwise stay in IDLE.
- COUNT:
  - Each cycle with bit_valid=1: sample_cnt increments with wrap; ones_cnt increments by bit_in.
  - Cycles with bit_valid=0 change neither counter.
  - Sample with sample_cnt == 2^WINDOW_LOG2-1 and bit_valid=1 is the last sample. The final count, including that sample, is latched into result/prob_est and the FSM goes to DONE.
  - start in COUNT is ignored.
- DONE:
  - result, prob_est and result_valid are held stable until the handshake.
  - Handshake with start=0: go to IDLE.
  - Handshake with start=1: go to COUNT with counters cleared (back-to-back windows).
  - start without handshake is ignored.
- abort in any state: next state IDLE, result_valid=0, counters cleared. result/prob_est keep their last latched value. abort has priority over start and over the handshake.
- ones_cnt never overflows; its width holds 2^WINDOW_LOG2.
- prob_est saturation: for WINDOW_LOG2=8, result=256 gives prob_est=8'hFF, and result=255 also gives 8'hFF. For larger windows the right shift applies first, then saturation.
- Reset (rst_b=0 at a clock edge), in any state including mid-window:
  - state returns to IDLE;
  - busy=0, result_valid=0, result=0, prob_est=0;
  - both counters are cleared.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- start sampled at edge t puts busy=1 after edge t. The first countable sample is the bit_in/bit_valid pair sampled at edge t+1.
- With bit_valid held high:
  - the last sample is taken at edge t+2^WINDOW_LOG2;
  - result_valid rises after that same edge, and busy falls after it;
  - latency from start to result_valid is 2^WINDOW_LOG2 cycles for WINDOW_LOG2=8 (256).
- Each cycle with bit_valid=0 during COUNT adds one cycle of latency.
- Handshake at edge h: result_valid=0 after h, unless start was also high at h. In that case busy=1 after h with zero idle cycles.
- abort or rst_b=0 at edge a: all flags are low after a.

## Test plan
- bit_in=1, bit_valid=1 continuously, start once, result_ready=1 -> result=256, prob_est=8'hFF, result_valid exactly 256 cycles after start.
- bit_in alternating 1,0, bit_valid=1 -> result=128, prob_est=8'h80; bit_in=0 throughout -> result=0, prob_est=0.
- bit_in=1, with bit_valid low every third cycle -> result=256 still, result_valid 384 cycles after start; the counted sample total is exactly 256.
- result_ready held low for 20 cycles in DONE, with start pulsed during that time -> result stable and start ignored. Then result_ready=1 together with start=1 -> second window starts, busy=1 the next cycle, result_valid=0.
- rst_b=0 for one cycle at sample 100 of a window, then a new start with all ones -> all outputs 0 after reset; the next window reports 256, with no carry-over. Repeat with abort in place of rst_b -> same outcome, except that the previous result is retained until it is overwritten.
- Driven by the LFSR comparator with seed 8'h4F and probability 8'h80, WINDOW_LOG2=10 -> result within 512±64, and prob_est equals result>>2 saturated.
